multi_alarm_mode_ctrl: RTL and testbench
========================================

Name: multi_alarm_mode_ctrl

Overview:
- Mode controller for the alarm clock; generalises the single clock/alarm select to N_ALARMS independent alarms.
- Cycles the user through a view state, a clock-edit state and one edit state per alarm on mode-button presses.
- Routes hour/minute edit presses as one-cycle pulses to the selected time counter, and selects the time shown on the display.
- Adds a blink phase for the edited field and an inactivity timeout that returns to view. Sits between the debouncers and the time counters/display driver.

Parameters:
- N_ALARMS, 2, number of alarm registers, 1..8.
- TIME_W, 17, time word width: [16:12] hours, [11:6] minutes, [5:0] seconds.
- TIMEOUT_S, 10, inactivity timeout in tick periods, 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse, 1 Hz.
- mode_btn  in  1  debounced level; rising edge advances mode.
- in_edit_btns  in  2  debounced levels; [1] hours, [0] minutes.
- current_time  in  TIME_W  running clock time.
- alarm_times  in  N_ALARMS*TIME_W  alarm k at [k*TIME_W +: TIME_W].
- clock_edit_btns  out  2  one-cycle increment pulses to clock counter.
- alarm_edit_btns  out  2*N_ALARMS  pulse pair for alarm k at [2k +: 2].
- display_time  out  TIME_W  time to display.
- mode_idx  out  MODE_W=$clog2(N_ALARMS+2)  0=VIEW, 1=CLK_EDIT, 2+k=ALM_EDIT k.
- blink  out  1  1 = edited field visible, 0 = blanked.

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Edge detection: per button, prev register; edge = level & ~prev. prev registers reset to 1, so a button held through reset produces no edge.
- Reset values: mode_idx=0, all edit pulse outputs 0, blink=1, timeout counter 0.
- State machine (registered mode_idx), on a mode edge: VIEW->CLK_EDIT->ALM_EDIT 0->...->ALM_EDIT N_ALARMS-1->VIEW. The new state is visible the cycle after the first cycle mode_btn is sampled high.
- Edit routing: an edit edge in cycle n gives a registered pulse on bit b of the selected destination in cycle n+1, exactly one cycle wide.
  - CLK_EDIT: destination is clock_edit_btns.
  - ALM_EDIT k: destination is alarm_edit_btns[2k+b].
  - VIEW: edit edges are discarded; no pulse.
  - Both edit bits edging in the same cycle: both pulse.
- Simultaneous mode edge and edit edge: the mode change wins and the edit edge is dropped, so no pulse reaches either the old or the new destination.
- display_time is combinational from mode_idx: VIEW/CLK_EDIT -> current_time; ALM_EDIT k -> alarm slice k.
- Timeout counter (8 bit):
  - Cleared on any mode edge, edit edge or state change.
  - Increments on tick in edit states; held at 0 in VIEW.
  - When the counter equals TIMEOUT_S-1 and a tick arrives, next state is VIEW and the counter clears.
  - Button edge coincident with the timeout tick: the button wins; no timeout; the edge is processed normally.
- Blink:
  - Forced 1 in VIEW.
  - Set to 1 on entry to any edit state and on any edit pulse.
  - Otherwise toggles on each tick while in an edit state.
- No wrap of time values here; counters downstream own range/wrap.
- Reset asserted mid-edit: next cycle state is VIEW, pulses 0, counter 0, blink 1, any in-flight edit pulse suppressed.

Test Plan:
- Reset with mode_btn held high, then release -> mode_idx stays 0 and no edit pulses appear.
- N_ALARMS=2, four mode presses -> mode_idx sequence 1,2,3,0; display_time equals current_time, current_time, alarm slice 0, alarm slice 1, current_time respectively.
- In ALM_EDIT 1, press hours, then minutes -> alarm_edit_btns=4'b1000 then 4'b0100, each for one cycle; clock_edit_btns stays 0.
- mode and hours edges in the same cycle in CLK_EDIT -> mode_idx=2, no pulse on any output.
- TIMEOUT_S=3 in CLK_EDIT, no buttons -> blink toggles 1,0,1 on ticks and mode_idx=0 after the 3rd tick; a minutes press on the 3rd tick -> mode_idx stays 1 and clock_edit_btns=2'b01.
- Reset asserted in ALM_EDIT 0 during a held edit press -> mode_idx=0, blink=1, all pulses 0 the next cycle.

Source files
------------

// File: rtl/multi_alarm_mode_ctrl_if.sv
// Purpose: bundles the user-interface signals of the alarm-clock mode controller:
//          button/tick/time inputs and the routed edit pulses, display time,
//          mode index and blink outputs.
// Modports:
//   master - drives tick, mode_btn, in_edit_btns, current_time, alarm_times;
//            observes the controller outputs.
//   slave  - the mode controller itself.
interface multi_alarm_mode_ctrl_if #(
  parameter int unsigned N_ALARMS = 2,
  parameter int unsigned TIME_W   = 17
);
  localparam int unsigned MODE_W = $clog2(N_ALARMS + 2);

  logic                         tick;
  logic                         mode_btn;
  logic [1:0]                   in_edit_btns;
  logic [TIME_W-1:0]            current_time;
  logic [N_ALARMS*TIME_W-1:0]   alarm_times;
  logic [1:0]                   clock_edit_btns;
  logic [2*N_ALARMS-1:0]        alarm_edit_btns;
  logic [TIME_W-1:0]            display_time;
  logic [MODE_W-1:0]            mode_idx;
  logic                         blink;

  modport master (
    output tick, mode_btn, in_edit_btns, current_time, alarm_times,
    input  clock_edit_btns, alarm_edit_btns, display_time, mode_idx, blink
  );

  modport slave (
    input  tick, mode_btn, in_edit_btns, current_time, alarm_times,
    output clock_edit_btns, alarm_edit_btns, display_time, mode_idx, blink
  );
endinterface

// File: rtl/multi_alarm_mode_ctrl.sv
// Purpose: alarm-clock mode controller with N_ALARMS alarms. Steps through
//          VIEW -> CLK_EDIT -> ALM_EDIT 0..N_ALARMS-1 -> VIEW on mode-button
//          presses, routes hour/minute presses as one-cycle pulses to the
//          selected time counter, selects the displayed time, blinks the edited
//          field and drops back to VIEW after TIMEOUT_S idle ticks.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - slave side of multi_alarm_mode_ctrl_if (buttons, tick, times in;
//            edit pulses, display_time, mode_idx, blink out)
module multi_alarm_mode_ctrl #(
  parameter int unsigned N_ALARMS  = 2,
  parameter int unsigned TIME_W    = 17,
  parameter int unsigned TIMEOUT_S = 10
) (
  input logic                    clk,
  input logic                    reset,
  multi_alarm_mode_ctrl_if.slave bus
);
  localparam int unsigned MODE_W    = $clog2(N_ALARMS + 2);
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned LAST_MODE = N_ALARMS + 1;

  typedef enum logic [MODE_W-1:0] {
    VIEW      = MODE_W'(0),
    CLK_EDIT  = MODE_W'(1),
    ALM_EDIT0 = MODE_W'(2)
  } mode_e;

  logic [MODE_W-1:0]     mode_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  blink_q;
  logic [1:0]            clk_pulse_q;
  logic [2*N_ALARMS-1:0] alm_pulse_q;
  logic                  mode_prev;
  logic [1:0]            edit_prev;

  logic                  mode_edge;
  logic [1:0]            edit_edge;
  logic                  in_edit;

  // Rising-edge detect; prev registers reset high so a held button is ignored.
  assign mode_edge = bus.mode_btn & ~mode_prev;
  assign edit_edge = bus.in_edit_btns & ~edit_prev;
  assign in_edit   = (mode_q != VIEW);

  // Mode FSM, timeout counter, blink phase and edit-pulse routing.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= VIEW;
      cnt_q       <= '0;
      blink_q     <= 1'b1;
      clk_pulse_q <= '0;
      alm_pulse_q <= '0;
      mode_prev   <= 1'b1;
      edit_prev   <= 2'b11;
    end else begin
      mode_prev   <= bus.mode_btn;
      edit_prev   <= bus.in_edit_btns;
      clk_pulse_q <= '0;
      alm_pulse_q <= '0;
      if (mode_edge) begin
        // Mode change wins over any coincident edit edge or tick.
        mode_q  <= (mode_q == MODE_W'(LAST_MODE)) ? VIEW : mode_q + MODE_W'(1);
        cnt_q   <= '0;
        blink_q <= 1'b1;
      end else if (!in_edit) begin
        cnt_q   <= '0;
        blink_q <= 1'b1;
      end else if (|edit_edge) begin
        // An edit press also beats a coincident timeout tick.
        cnt_q   <= '0;
        blink_q <= 1'b1;
        if (mode_q == CLK_EDIT) begin
          clk_pulse_q <= edit_edge;
        end
        for (int k = 0; k < int'(N_ALARMS); k++) begin
          if (mode_q == MODE_W'(int'(ALM_EDIT0) + k)) begin
            alm_pulse_q[2*k +: 2] <= edit_edge;
          end
        end
      end else if (bus.tick) begin
        if (cnt_q == CNT_W'(TIMEOUT_S - 1)) begin
          mode_q  <= VIEW;
          cnt_q   <= '0;
          blink_q <= 1'b1;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          blink_q <= ~blink_q;
        end
      end
    end
  end

  // Display mux: alarm slice while editing that alarm, otherwise running time.
  always_comb begin
    bus.display_time = bus.current_time;
    for (int k = 0; k < int'(N_ALARMS); k++) begin
      if (mode_q == MODE_W'(int'(ALM_EDIT0) + k)) begin
        bus.display_time = bus.alarm_times[k*TIME_W +: TIME_W];
      end
    end
  end

  assign bus.mode_idx        = mode_q;
  assign bus.blink           = blink_q;
  assign bus.clock_edit_btns = clk_pulse_q;
  assign bus.alarm_edit_btns = alm_pulse_q;

endmodule

// File: tb/tb_multi_alarm_mode_ctrl.sv
// Purpose: self-checking bench for multi_alarm_mode_ctrl (N_ALARMS=2,
//          TIME_W=17, TIMEOUT_S=3) with directed scenarios and a randomized
//          run against a behavioural model.
module tb_multi_alarm_mode_ctrl;
  localparam int unsigned N   = 2;
  localparam int unsigned TW  = 17;
  localparam int unsigned TO  = 3;
  localparam int unsigned MW  = $clog2(N + 2);
  localparam int unsigned AW  = 2 * N;
  localparam int unsigned ATW = N * TW;

  logic clk = 1'b0;
  logic reset;

  multi_alarm_mode_ctrl_if #(.N_ALARMS(N), .TIME_W(TW)) bus ();

  multi_alarm_mode_ctrl #(.N_ALARMS(N), .TIME_W(TW), .TIMEOUT_S(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int            m_mode;
  int            m_idle;
  logic          m_blink;
  logic          m_pm;
  logic [1:0]    m_pe;
  logic [1:0]    m_clk_p;
  logic [AW-1:0] m_alm_p;

  // One clock of the model: mode presses cycle through N+2 modes, edit
  // presses in an edit mode make a pulse, TO idle ticks fall back to view.
  function automatic void model_step();
    logic       me;
    logic [1:0] ee;
    if (reset) begin
      m_mode = 0; m_idle = 0; m_blink = 1'b1;
      m_pm = 1'b1; m_pe = 2'b11; m_clk_p = '0; m_alm_p = '0;
      return;
    end
    me = bus.mode_btn & ~m_pm;
    ee = bus.in_edit_btns & ~m_pe;
    m_pm = bus.mode_btn;
    m_pe = bus.in_edit_btns;
    m_clk_p = '0;
    m_alm_p = '0;
    if (me) begin
      m_mode = (m_mode + 1) % (int'(N) + 2);
      m_idle = 0;
      m_blink = 1'b1;
    end else if (m_mode == 0) begin
      m_idle = 0;
      m_blink = 1'b1;
    end else if (ee != 2'b00) begin
      m_idle = 0;
      m_blink = 1'b1;
      if (m_mode == 1) m_clk_p = ee;
      else m_alm_p = AW'(ee) << (2 * (m_mode - 2));
    end else if (bus.tick) begin
      m_idle = m_idle + 1;
      if (m_idle >= int'(TO)) begin
        m_mode = 0;
        m_idle = 0;
        m_blink = 1'b1;
      end else begin
        m_blink = ~m_blink;
      end
    end
  endfunction

  function automatic logic [TW-1:0] disp_for(int mode);
    if (mode >= 2) return TW'(bus.alarm_times >> ((mode - 2) * int'(TW)));
    return bus.current_time;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press_mode();
    bus.mode_btn = 1'b1;
    step();
    bus.mode_btn = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mode_btn = 1'b1;
    bus.in_edit_btns = 2'b11;
    bus.tick = 1'b1;
    step();
    step();
    checks++;
    if (bus.mode_idx !== MW'(0)) begin
      errors++; $display("FAIL reset_mode: got %0d expected 0", bus.mode_idx);
    end
    checks++;
    if (bus.blink !== 1'b1) begin
      errors++; $display("FAIL reset_blink: got %b expected 1", bus.blink);
    end
    checks++;
    if (bus.clock_edit_btns !== 2'b00 || bus.alarm_edit_btns !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got clk=%b alm=%b expected 0", bus.clock_edit_btns, bus.alarm_edit_btns);
    end
    reset = 1'b0;
    bus.tick = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (bus.mode_idx !== MW'(0) || bus.clock_edit_btns !== 2'b00 || bus.alarm_edit_btns !== 4'b0000) begin
        errors++; $display("FAIL held_through_reset: got mode=%0d clk=%b alm=%b expected 0/00/0000", bus.mode_idx, bus.clock_edit_btns, bus.alarm_edit_btns);
      end
    end
    bus.mode_btn = 1'b0;
    bus.in_edit_btns = 2'b00;
    step();
    checks++;
    if (bus.mode_idx !== MW'(0)) begin
      errors++; $display("FAIL release_after_reset: got mode=%0d expected 0", bus.mode_idx);
    end
  endtask

  task automatic test_mode_cycle();
    int exp_seq[4] = '{1, 2, 3, 0};
    bus.current_time = TW'($urandom());
    bus.alarm_times  = ATW'({$urandom(), $urandom()});
    step();
    checks++;
    if (bus.display_time !== bus.current_time) begin
      errors++; $display("FAIL display_view: got %h expected %h", bus.display_time, bus.current_time);
    end
    for (int i = 0; i < 4; i++) begin
      bus.mode_btn = 1'b1;
      step();
      checks++;
      if (bus.mode_idx !== MW'(exp_seq[i])) begin
        errors++; $display("FAIL mode_seq[%0d]: got %0d expected %0d", i, bus.mode_idx, exp_seq[i]);
      end
      checks++;
      if (bus.display_time !== disp_for(exp_seq[i])) begin
        errors++; $display("FAIL display_seq[%0d]: got %h expected %h", i, bus.display_time, disp_for(exp_seq[i]));
      end
      bus.mode_btn = 1'b0;
      step();
    end
  endtask

  task automatic test_alarm_edit();
    repeat (3) press_mode();
    checks++;
    if (bus.mode_idx !== MW'(3)) begin
      errors++; $display("FAIL alm1_entry: got %0d expected 3", bus.mode_idx);
    end
    bus.in_edit_btns = 2'b10;
    step();
    checks++;
    if (bus.alarm_edit_btns !== 4'b1000 || bus.clock_edit_btns !== 2'b00) begin
      errors++; $display("FAIL alm1_hours: got alm=%b clk=%b expected 1000/00", bus.alarm_edit_btns, bus.clock_edit_btns);
    end
    bus.in_edit_btns = 2'b00;
    step();
    checks++;
    if (bus.alarm_edit_btns !== 4'b0000) begin
      errors++; $display("FAIL alm1_hours_width: got %b expected 0000", bus.alarm_edit_btns);
    end
    bus.in_edit_btns = 2'b01;
    step();
    checks++;
    if (bus.alarm_edit_btns !== 4'b0100 || bus.clock_edit_btns !== 2'b00) begin
      errors++; $display("FAIL alm1_minutes: got alm=%b clk=%b expected 0100/00", bus.alarm_edit_btns, bus.clock_edit_btns);
    end
    bus.in_edit_btns = 2'b00;
    step();
    checks++;
    if (bus.alarm_edit_btns !== 4'b0000) begin
      errors++; $display("FAIL alm1_minutes_width: got %b expected 0000", bus.alarm_edit_btns);
    end
    press_mode();
  endtask

  task automatic test_simultaneous();
    press_mode();
    bus.mode_btn = 1'b1;
    bus.in_edit_btns = 2'b10;
    step();
    checks++;
    if (bus.mode_idx !== MW'(2)) begin
      errors++; $display("FAIL simul_mode: got %0d expected 2", bus.mode_idx);
    end
    checks++;
    if (bus.clock_edit_btns !== 2'b00 || bus.alarm_edit_btns !== 4'b0000) begin
      errors++; $display("FAIL simul_pulse: got clk=%b alm=%b expected 00/0000", bus.clock_edit_btns, bus.alarm_edit_btns);
    end
    step();
    checks++;
    if (bus.clock_edit_btns !== 2'b00 || bus.alarm_edit_btns !== 4'b0000) begin
      errors++; $display("FAIL simul_held: got clk=%b alm=%b expected 00/0000", bus.clock_edit_btns, bus.alarm_edit_btns);
    end
    bus.mode_btn = 1'b0;
    bus.in_edit_btns = 2'b00;
    step();
    repeat (2) press_mode();
    checks++;
    if (bus.mode_idx !== MW'(0)) begin
      errors++; $display("FAIL simul_return: got %0d expected 0", bus.mode_idx);
    end
  endtask

  task automatic test_timeout();
    logic exp_bl[3] = '{1'b0, 1'b1, 1'b1};
    int   exp_md[3] = '{1, 1, 0};
    press_mode();
    checks++;
    if (bus.blink !== 1'b1) begin
      errors++; $display("FAIL to_entry_blink: got %b expected 1", bus.blink);
    end
    for (int i = 0; i < 3; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      checks++;
      if (bus.blink !== exp_bl[i] || bus.mode_idx !== MW'(exp_md[i])) begin
        errors++; $display("FAIL to_tick[%0d]: got blink=%b mode=%0d expected %b/%0d", i, bus.blink, bus.mode_idx, exp_bl[i], exp_md[i]);
      end
      step();
    end
    press_mode();
    repeat (2) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
    bus.tick = 1'b1;
    bus.in_edit_btns = 2'b01;
    step();
    bus.tick = 1'b0;
    bus.in_edit_btns = 2'b00;
    checks++;
    if (bus.mode_idx !== MW'(1) || bus.clock_edit_btns !== 2'b01) begin
      errors++; $display("FAIL to_button_wins: got mode=%0d clk=%b expected 1/01", bus.mode_idx, bus.clock_edit_btns);
    end
    checks++;
    if (bus.blink !== 1'b1) begin
      errors++; $display("FAIL to_button_blink: got %b expected 1", bus.blink);
    end
    step();
    checks++;
    if (bus.clock_edit_btns !== 2'b00) begin
      errors++; $display("FAIL to_button_width: got %b expected 00", bus.clock_edit_btns);
    end
    repeat (3) press_mode();
  endtask

  task automatic test_reset_mid_edit();
    repeat (2) press_mode();
    bus.in_edit_btns = 2'b01;
    step();
    checks++;
    if (bus.alarm_edit_btns !== 4'b0001) begin
      errors++; $display("FAIL alm0_minutes: got %b expected 0001", bus.alarm_edit_btns);
    end
    reset = 1'b1;
    bus.in_edit_btns = 2'b11;
    step();
    reset = 1'b0;
    checks++;
    if (bus.mode_idx !== MW'(0) || bus.blink !== 1'b1) begin
      errors++; $display("FAIL mid_reset_state: got mode=%0d blink=%b expected 0/1", bus.mode_idx, bus.blink);
    end
    checks++;
    if (bus.clock_edit_btns !== 2'b00 || bus.alarm_edit_btns !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_pulses: got clk=%b alm=%b expected 00/0000", bus.clock_edit_btns, bus.alarm_edit_btns);
    end
    step();
    checks++;
    if (bus.alarm_edit_btns !== 4'b0000 || bus.mode_idx !== MW'(0)) begin
      errors++; $display("FAIL post_reset_held: got alm=%b mode=%0d expected 0000/0", bus.alarm_edit_btns, bus.mode_idx);
    end
    bus.in_edit_btns = 2'b00;
    step();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) bus.mode_btn = ~bus.mode_btn;
      if ($urandom_range(0, 2) == 0) bus.in_edit_btns[0] = ~bus.in_edit_btns[0];
      if ($urandom_range(0, 2) == 0) bus.in_edit_btns[1] = ~bus.in_edit_btns[1];
      bus.tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.current_time = TW'($urandom());
        bus.alarm_times  = ATW'({$urandom(), $urandom()});
      end
      step();
      checks++;
      if (bus.mode_idx !== MW'(m_mode)) begin
        errors++; $display("FAIL rnd_mode @%0d: got %0d expected %0d", cyc, bus.mode_idx, m_mode);
      end
      checks++;
      if (bus.blink !== m_blink) begin
        errors++; $display("FAIL rnd_blink @%0d: got %b expected %b", cyc, bus.blink, m_blink);
      end
      checks++;
      if (bus.clock_edit_btns !== m_clk_p) begin
        errors++; $display("FAIL rnd_clk_pulse @%0d: got %b expected %b", cyc, bus.clock_edit_btns, m_clk_p);
      end
      checks++;
      if (bus.alarm_edit_btns !== m_alm_p) begin
        errors++; $display("FAIL rnd_alm_pulse @%0d: got %b expected %b", cyc, bus.alarm_edit_btns, m_alm_p);
      end
      checks++;
      if (bus.display_time !== disp_for(m_mode)) begin
        errors++; $display("FAIL rnd_display @%0d: got %h expected %h", cyc, bus.display_time, disp_for(m_mode));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.tick = 1'b0;
    bus.mode_btn = 1'b0;
    bus.in_edit_btns = 2'b00;
    bus.current_time = '0;
    bus.alarm_times = '0;
    test_reset();
    test_mode_cycle();
    test_alarm_edit();
    test_simultaneous();
    test_timeout();
    test_reset_mid_edit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
